rob_tag_allocator: RTL and testbench
====================================

// Module: rob_tag_allocator
// PURPOSE
//  Dispatch-side partner of the reorder buffer. Hands out ROB ids in program order and
//  drives the ROB tail pointer. Tracks in-flight entries and stalls dispatch when all
//  1<<ID_SIZE slots are used. Records each entry's destination register so decode can ask
//  whether a source register is still pending, and on which id.
// PARAMETERS
//  REG_ADDRESS_SIZE  5  width of register-file address
//  ID_SIZE           2  ROB id width; DEPTH = 1<<ID_SIZE entries
// PORTS
//  clk            in   1                   single clock, all state updates on posedge
//  reset          in   1                   synchronous, active-high
//  alloc_req      in   1                   dispatch requests an id this cycle
//  alloc_address  in   REG_ADDRESS_SIZE    destination register of the instruction
//  alloc_w        in   1                   instruction writes alloc_address
//  alloc_stall    out  1                   request not accepted this cycle
//  alloc_id       out  ID_SIZE             id granted (== tail) when alloc_req && !alloc_stall
//  tail           out  ID_SIZE             next id to allocate; wired to the ROB tail input
//  commit         in   1                   ROB retired its head entry this cycle
//  src1_address   in   REG_ADDRESS_SIZE    lookup address, operand 1
//  src1_pending   out  1                   an in-flight entry will write src1_address
//  src1_id        out  ID_SIZE             youngest such entry
//  src2_address / src2_pending / src2_id   same as src1, operand 2
//  count          out  ID_SIZE+1           entries in flight, 0..DEPTH
//  commit_error   out  1                   sticky: commit seen while count==0
// BEHAVIOUR
//  - State: head, tail (ID_SIZE, wrap modulo DEPTH), count, and per slot {valid, w, address}.
//  - Reset, in the cycle after reset=1: head=tail=0, count=0, all valid=0, commit_error=0.
//    All outputs then read 0. Reset beats every other input, including mid-allocation.
//  - Accept = alloc_req && !alloc_stall. alloc_stall = (count==DEPTH), combinational.
//    No same-cycle bypass: a full queue stalls even when commit is high that cycle.
//  - On accept: slot[tail] <= {1, alloc_w, alloc_address}; tail <= tail+1.
//    alloc_id = tail, combinational, zero-latency grant.
//  - On commit with count>0: slot[head].valid <= 0; head <= head+1.
//  - On commit with count==0: no state change; commit_error <= 1 (sticky until reset).
//  - count next = count + accept - (commit && count>0). Accept and commit in the same cycle
//    leave count unchanged, and both pointers advance.
//  - Full/empty is decided by count only; head==tail is ambiguous and is never used.
//  - Lookup is combinational over registered state only:
//    - pending = any slot with valid && w && address==src_address, and src_address != 0.
//      Register 0 is never pending.
//    - id = youngest match, i.e. the largest (slot-head) mod DEPTH.
//    - No match: pending=0, id=0.
//    - An allocation made this cycle is not visible until the next cycle.
//    - An entry committing this cycle is still reported pending this cycle.
//  - head is internal. It must track the ROB's own head; commit is the ROB's retire strobe.
// CONFIGURATION
//  ROB_ALLOC_FLUSH_EN defined: adds input port flush (1 bit).
//    - flush=1 at a posedge: all valid <= 0, tail <= head, count <= 0.
//    - flush beats alloc_req and commit that cycle; alloc_stall=1 while flush=1.
//    - commit_error is unaffected. The ROB must discard its entries in the same cycle.
//  Undefined: no flush port. Entries clear only by commit or reset.
// TESTING (ID_SIZE=2, DEPTH=4)
//  1. Reset, then 4 back-to-back alloc_req -> alloc_id 0,1,2,3; count=4;
//     5th request sees alloc_stall=1 and tail stays 0.
//  2. Full, then commit and alloc_req in the same cycle -> request still stalled, count=3.
//     Next cycle alloc accepted with id=0, count=4.
//  3. Alloc r5 (id0), alloc r5 (id1), alloc r7 w=0 (id2); lookup src1=5 -> pending=1, id=1.
//     src2=7 -> pending=0. Commit twice -> src1=5 pending=0.
//  4. Wrap: run 6 alloc/commit pairs with one outstanding entry, then alloc r3 at slot 3
//     and r3 at slot 0 -> id=0 reported (youngest across wrap).
//  5. Commit with count=0 -> commit_error=1, count stays 0. Alloc r0 then lookup 0 -> pending=0.
//  6. reset asserted with count=3 -> next cycle count=0, tail=0, no pending lookups.
//     With ROB_ALLOC_FLUSH_EN: flush at count=2, head=1 -> tail=1, count=0.

Source files
------------

// File: rtl/rob_tag_allocator.sv
// rtl/rob_tag_allocator.sv - ROB id allocator with in-flight destination tracking
//
// Hands out reorder-buffer ids in program order, drives the ROB tail pointer,
// stalls dispatch when every slot is in flight, and answers "is this source
// register still being produced, and by which id" for two decode operands.
//
// Optional feature: define ROB_ALLOC_FLUSH_EN to add the flush input, which
// discards every in-flight entry (tail snaps back to head, count to zero).
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   alloc_req/address/w         dispatch request, destination reg, writes-dest flag
//   alloc_stall, alloc_id       request refused this cycle; id granted (== tail)
//   tail                        next id to allocate, wired to the ROB tail input
//   commit                      ROB retired its head entry this cycle
//   srcN_address/pending/id     operand lookup: pending flag and youngest producer id
//   count                       entries in flight, 0..DEPTH
//   commit_error                sticky: commit seen while nothing was in flight
//   flush (optional)            drop all in-flight entries

module rob_tag_allocator #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int ID_SIZE          = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_req,
    input  logic [REG_ADDRESS_SIZE-1:0] alloc_address,
    input  logic                        alloc_w,
    output logic                        alloc_stall,
    output logic [ID_SIZE-1:0]          alloc_id,
    output logic [ID_SIZE-1:0]          tail,
    input  logic                        commit,
    input  logic [REG_ADDRESS_SIZE-1:0] src1_address,
    output logic                        src1_pending,
    output logic [ID_SIZE-1:0]          src1_id,
    input  logic [REG_ADDRESS_SIZE-1:0] src2_address,
    output logic                        src2_pending,
    output logic [ID_SIZE-1:0]          src2_id,
    output logic [ID_SIZE:0]            count,
    output logic                        commit_error
`ifdef ROB_ALLOC_FLUSH_EN
    ,
    input  logic                        flush
`endif
);

    localparam int                DEPTH   = 1 << ID_SIZE;
    localparam logic [ID_SIZE:0]  FULL    = (ID_SIZE+1)'(DEPTH);
    localparam logic [ID_SIZE:0]  ONE_CNT = (ID_SIZE+1)'(1);
    localparam logic [ID_SIZE-1:0] ONE_ID = ID_SIZE'(1);

    logic [ID_SIZE-1:0]          head;
    logic [DEPTH-1:0]            slot_valid;
    logic [DEPTH-1:0]            slot_w;
    logic [REG_ADDRESS_SIZE-1:0] slot_addr [DEPTH];

    logic accept;
    logic do_commit;
    logic [ID_SIZE:0] count_next;

    // Fullness comes from count alone; head==tail cannot tell full from empty.
    // A commit in the same cycle does not free a slot for this cycle's request.
`ifdef ROB_ALLOC_FLUSH_EN
    assign alloc_stall = (count == FULL) || flush;
`else
    assign alloc_stall = (count == FULL);
`endif
    assign accept    = alloc_req && !alloc_stall;
    assign do_commit = commit && (count != '0);
    assign alloc_id  = tail;

    always_comb begin
        count_next = count;
        case ({accept, do_commit})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    // Walk slots oldest to youngest starting at head; a later match overwrites
    // an earlier one so the youngest producer wins, including across the wrap.
    always_comb begin
        src1_pending = 1'b0;
        src1_id      = '0;
        src2_pending = 1'b0;
        src2_id      = '0;
        for (int age = 0; age < DEPTH; age++) begin
            logic [ID_SIZE-1:0] slot;
            slot = head + ID_SIZE'(age);
            if (slot_valid[slot] && slot_w[slot] && src1_address != '0 &&
                slot_addr[slot] == src1_address) begin
                src1_pending = 1'b1;
                src1_id      = slot;
            end
            if (slot_valid[slot] && slot_w[slot] && src2_address != '0 &&
                slot_addr[slot] == src2_address) begin
                src2_pending = 1'b1;
                src2_id      = slot;
            end
        end
    end

    // Accept and commit never touch the same slot in one cycle: accept needs
    // count<DEPTH and commit needs count>0, so tail==head cannot coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            slot_valid   <= '0;
            commit_error <= 1'b0;
        end
`ifdef ROB_ALLOC_FLUSH_EN
        else if (flush) begin
            slot_valid <= '0;
            tail       <= head;
            count      <= '0;
        end
`endif
        else begin
            if (accept) begin
                slot_valid[tail] <= 1'b1;
                slot_w[tail]     <= alloc_w;
                slot_addr[tail]  <= alloc_address;
                tail             <= tail + ONE_ID;
            end
            if (do_commit) begin
                slot_valid[head] <= 1'b0;
                head             <= head + ONE_ID;
            end else if (commit) begin
                commit_error <= 1'b1;
            end
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_rob_tag_allocator.sv
// tb/tb_rob_tag_allocator.sv - scoreboard bench for rob_tag_allocator

module tb_rob_tag_allocator;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic [4:0] alloc_address;
    logic       alloc_w;
    logic       alloc_stall;
    logic [1:0] alloc_id;
    logic [1:0] tail;
    logic       commit;
    logic [4:0] src1_address;
    logic       src1_pending;
    logic [1:0] src1_id;
    logic [4:0] src2_address;
    logic       src2_pending;
    logic [1:0] src2_id;
    logic [2:0] count;
    logic       commit_error;
`ifdef ROB_ALLOC_FLUSH_EN
    logic       flush = 1'b0;
`endif

    rob_tag_allocator #(.REG_ADDRESS_SIZE(5), .ID_SIZE(2)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_address(alloc_address), .alloc_w(alloc_w),
        .alloc_stall(alloc_stall), .alloc_id(alloc_id), .tail(tail),
        .commit(commit),
        .src1_address(src1_address), .src1_pending(src1_pending), .src1_id(src1_id),
        .src2_address(src2_address), .src2_pending(src2_pending), .src2_id(src2_id),
        .count(count), .commit_error(commit_error)
`ifdef ROB_ALLOC_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {K_COUNT, K_TAIL, K_STALL, K_CERR, K_P1, K_ID1, K_P2, K_ID2} kind_e;
    typedef struct {
        int    cyc;
        kind_e k;
        int    v;
    } chk_t;

    chk_t q[$];
    int   gq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input kind_e k);
        case (k)
            K_COUNT: return int'(count);
            K_TAIL:  return int'(tail);
            K_STALL: return int'(alloc_stall);
            K_CERR:  return int'(commit_error);
            K_P1:    return int'(src1_pending);
            K_ID1:   return int'(src1_id);
            K_P2:    return int'(src2_pending);
            default: return int'(src2_id);
        endcase
    endfunction

    // Monitor: grants are checked whenever the DUT accepts a request; state
    // and lookup checks are checked in the cycle they were queued for.
    initial begin
        forever begin
            @(negedge clk);
            if (alloc_req && !alloc_stall && !reset) begin
                n_tests++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant cyc=%0d got id=%0d required no grant", cyc, alloc_id);
                end else begin
                    int e;
                    e = gq.pop_front();
                    if (int'(alloc_id) != e) begin
                        n_fail++;
                        $display("FAIL alloc_id cyc=%0d got %0d required %0d", cyc, alloc_id, e);
                    end
                end
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                chk_t c;
                int   a;
                c = q.pop_front();
                a = actual(c.k);
                n_tests++;
                if (a != c.v || c.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got %0d required %0d", c.k.name(), cyc, a, c.v);
                end
            end
        end
    end

    task automatic chk(input kind_e k, input int v);
        chk_t c;
        c.cyc = cyc;
        c.k   = k;
        c.v   = v;
        q.push_back(c);
    endtask

    task automatic grant(input int id);
        gq.push_back(id);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input int a, input logic w, input logic c);
        alloc_req     = r;
        alloc_address = a[4:0];
        alloc_w       = w;
        commit        = c;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        src1_address = '0;
        src2_address = '0;
        tick();
        tick();
        reset = 1'b0;
        src1_address = 5'd5;
        chk(K_COUNT, 0); chk(K_TAIL, 0); chk(K_STALL, 0); chk(K_CERR, 0);
        chk(K_P1, 0); chk(K_ID1, 0);

        // fill to DEPTH, then a fifth request stalls
        for (int i = 0; i < 4; i++) begin
            drive(1, i + 1, 1, 0); grant(i); chk(K_STALL, 0); tick();
        end
        chk(K_COUNT, 4); chk(K_STALL, 1); chk(K_TAIL, 0);
        tick();
        chk(K_COUNT, 4); chk(K_TAIL, 0);

        // full + commit + request: still stalled; next cycle accepted with id 0
        drive(1, 9, 1, 1); chk(K_STALL, 1); tick();
        chk(K_COUNT, 3);
        drive(1, 9, 1, 0); chk(K_STALL, 0); grant(0); tick();
        chk(K_COUNT, 4); chk(K_TAIL, 1);

        // reset with count=3 beats a concurrent request and commit
        drive(0, 0, 0, 1); tick();
        chk(K_COUNT, 3);
        reset = 1'b1; drive(1, 6, 1, 1); tick();
        reset = 1'b0; drive(0, 0, 0, 0);
        src1_address = 5'd2; src2_address = 5'd9;
        chk(K_COUNT, 0); chk(K_TAIL, 0); chk(K_STALL, 0); chk(K_P1, 0); chk(K_P2, 0);

        // youngest match, w=0 never pending, same-cycle alloc/commit visibility
        drive(1, 5, 1, 0); grant(0); tick();
        drive(1, 5, 1, 0); grant(1); src1_address = 5'd5;
        chk(K_P1, 1); chk(K_ID1, 0); tick();
        drive(1, 7, 0, 0); grant(2); tick();
        drive(0, 0, 0, 1); src2_address = 5'd7;
        chk(K_P1, 1); chk(K_ID1, 1); chk(K_P2, 0); chk(K_ID2, 0); tick();
        drive(0, 0, 0, 1); chk(K_P1, 1); chk(K_ID1, 1); tick();
        drive(0, 0, 0, 0); chk(K_P1, 0); chk(K_ID1, 0); chk(K_COUNT, 1);

        // wrap: alloc/commit pairs with one entry outstanding (head=2, tail=3)
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, 1, 1); grant((3 + i) % 4); chk(K_COUNT, 1); tick();
        end
        drive(1, 3, 1, 0); grant(3); tick();
        drive(1, 3, 1, 0); grant(0); tick();
        drive(0, 0, 0, 0); src1_address = 5'd3; src2_address = 5'd13;
        chk(K_P1, 1); chk(K_ID1, 0); chk(K_P2, 1); chk(K_ID2, 2);
        chk(K_COUNT, 3); chk(K_TAIL, 1);

        // drain, then commit on empty -> sticky commit_error; r0 never pending
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1); tick();
        end
        drive(0, 0, 0, 1); chk(K_COUNT, 0); chk(K_CERR, 0); tick();
        drive(1, 0, 1, 0); grant(1); chk(K_CERR, 1); chk(K_COUNT, 0); tick();
        drive(0, 0, 0, 0); src1_address = 5'd0;
        chk(K_P1, 0); chk(K_ID1, 0); chk(K_COUNT, 1); chk(K_CERR, 1); chk(K_TAIL, 2);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk(K_CERR, 0); chk(K_COUNT, 0); chk(K_TAIL, 0);

`ifdef ROB_ALLOC_FLUSH_EN
        // flush at count=2, head=1 -> tail=1, count=0
        drive(1, 4, 1, 0); grant(0); tick();
        grant(1); tick();
        grant(2); tick();
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0); chk(K_COUNT, 2);
        flush = 1'b1; drive(1, 4, 1, 0); chk(K_STALL, 1); tick();
        flush = 1'b0; drive(0, 0, 0, 0); src1_address = 5'd4;
        chk(K_TAIL, 1); chk(K_COUNT, 0); chk(K_P1, 0);
`endif

        drive(0, 0, 0, 0);
        tick();
        tick();
        n_tests++;
        if (gq.size() != 0) begin
            n_fail++;
            $display("FAIL grants_outstanding got %0d missing grants required 0", gq.size());
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL checks_outstanding got %0d unchecked required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
